mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit for the 5-stage RV32I pipeline.
- Consumes the EX/MEM pipeline register outputs and runs the data-memory req/ack handshake.
- Stalls upstream stages while an access is outstanding, formats load/store data by funct3, and drives the MEM/WB register.

---
 rtl/mem_stage_lsu.sv | 172 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: EX/MEM -> data-memory req/ack handshake -> MEM/WB.
// Stalls upstream while an access is outstanding and aborts on an ack timeout.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic        memtoReg_in,
    input  logic        regWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] ALU_res_in,
    input  logic [31:0] rd2_in,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        regWrite_out,
    output logic        memtoReg_out,
    output logic [31:0] read_data_out,
    output logic [31:0] ALU_res_out,
    output logic [4:0]  rd_out
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mem_op;
    logic             misaligned;

    logic [2:0]  f3_q;
    logic [31:0] alu_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic        mtr_q;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'b0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'b0, h};
            default: fmt_load = word;
        endcase
    endfunction

    function automatic logic [31:0] fmt_wdata(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            3'b000, 3'b100: fmt_wdata = {4{data[7:0]}};
            3'b001, 3'b101: fmt_wdata = {2{data[15:0]}};
            default:        fmt_wdata = data;
        endcase
    endfunction

    function automatic logic [3:0] fmt_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: fmt_be = 4'b0001 << off;
            3'b001, 3'b101: fmt_be = off[1] ? 4'b1100 : 4'b0011;
            default:        fmt_be = 4'b1111;
        endcase
    endfunction

    assign mem_op = memRead_in | memWrite_in;

    always_comb begin
        case (funct3_in)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = ALU_res_in[0];
            default:        misaligned = |ALU_res_in[1:0];
        endcase
    end

    // In BUSY the EX/MEM register is frozen, so stall must fall in the ack cycle to let it advance.
    assign stall = (state == IDLE) ? (mem_op & ~misaligned & ~flush) : ~dmem_ack;

    // Snapshot of the instruction entering BUSY, used to fill MEM/WB on completion.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            f3_q  <= funct3_in;
            alu_q <= ALU_res_in;
            rd_q  <= rd_in;
            rw_q  <= regWrite_in;
            mtr_q <= memtoReg_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
            regWrite_out  <= 1'b0;
            memtoReg_out  <= 1'b0;
            read_data_out <= '0;
            ALU_res_out   <= '0;
            rd_out        <= '0;
        end else begin
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
            regWrite_out  <= 1'b0;
            memtoReg_out  <= 1'b0;
            read_data_out <= '0;
            ALU_res_out   <= '0;
            rd_out        <= '0;
            case (state)
                IDLE: begin
                    if (!flush) begin
                        if (!mem_op) begin
                            regWrite_out <= regWrite_in;
                            memtoReg_out <= memtoReg_in;
                            ALU_res_out  <= ALU_res_in;
                            rd_out       <= rd_in;
                        end else if (misaligned) begin
                            misalign_err <= 1'b1;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= memWrite_in;
                            dmem_addr  <= {ALU_res_in[31:2], 2'b00};
                            dmem_wdata <= fmt_wdata(funct3_in, rd2_in);
                            dmem_be    <= fmt_be(funct3_in, ALU_res_in[1:0]);
                            cnt        <= '0;
                            state      <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        regWrite_out  <= rw_q;
                        memtoReg_out  <= mtr_q;
                        ALU_res_out   <= alu_q;
                        rd_out        <= rd_q;
                        read_data_out <= dmem_we ? 32'b0 : fmt_load(f3_q, alu_q[1:0], dmem_rdata);
                        state         <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu with an instruction-level reference model.
module tb_mem_stage_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        memRead_in, memWrite_in, memtoReg_in, regWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] ALU_res_in, rd2_in;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, misalign_err, bus_err;
    logic        regWrite_out, memtoReg_out;
    logic [31:0] read_data_out, ALU_res_out;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .memtoReg_in(memtoReg_in), .regWrite_in(regWrite_in),
        .funct3_in(funct3_in), .ALU_res_in(ALU_res_in), .rd2_in(rd2_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall(stall), .misalign_err(misalign_err),
        .bus_err(bus_err), .regWrite_out(regWrite_out), .memtoReg_out(memtoReg_out),
        .read_data_out(read_data_out), .ALU_res_out(ALU_res_out), .rd_out(rd_out)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        e_stall, e_req, e_we, e_mis, e_bus, e_rw, e_mtr;
    logic [31:0] e_addr, e_wdata, e_rdata, e_alu;
    logic [3:0]  e_be;
    logic [4:0]  e_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(e_stall));
            check("dmem_req", 32'(dmem_req), 32'(e_req));
            check("misalign_err", 32'(misalign_err), 32'(e_mis));
            check("bus_err", 32'(bus_err), 32'(e_bus));
            check("regWrite_out", 32'(regWrite_out), 32'(e_rw));
            check("memtoReg_out", 32'(memtoReg_out), 32'(e_mtr));
            check("read_data_out", read_data_out, e_rdata);
            check("ALU_res_out", ALU_res_out, e_alu);
            check("rd_out", 32'(rd_out), 32'(e_rd));
            if (e_req) begin
                check("dmem_we", 32'(dmem_we), 32'(e_we));
                check("dmem_addr", dmem_addr, e_addr);
                check("dmem_wdata", dmem_wdata, e_wdata);
                check("dmem_be", 32'(dmem_be), 32'(e_be));
            end
        end
    end

    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % m_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
        int o;
        logic [31:0] v;
        o = int'(addr[1:0]);
        v = w;
        if (m_size(f3) == 1) begin
            v = (w >> (8 * o)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (m_size(f3) == 2) begin
            v = (w >> (16 * (o / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (m_size(f3) == 1) return {24'b0, d[7:0]} * 32'h01010101;
        if (m_size(f3) == 2) return {16'b0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = m_size(f3);
        return 4'(((1 << sz) - 1) << int'(addr[1:0]));
    endfunction

    task automatic zero_memwb();
        e_rw = 1'b0; e_mtr = 1'b0; e_rdata = '0; e_alu = '0; e_rd = '0;
    endtask

    task automatic set_nop();
        memRead_in = 1'b0; memWrite_in = 1'b0; memtoReg_in = 1'b0; regWrite_in = 1'b0;
        flush = 1'b0; funct3_in = '0; ALU_res_in = '0; rd2_in = '0; rd_in = '0;
    endtask

    // Called just after a rising edge; returns just after the edge that retires the op.
    task automatic do_op(input bit rd_en, input bit wr_en, input bit mtr, input bit rw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd2,
                         input logic [4:0] rd, input bit fl, input int ack_k,
                         input logic [31:0] rdata, input int abort_j);
        bit memop, mis;
        memRead_in = rd_en; memWrite_in = wr_en; memtoReg_in = mtr; regWrite_in = rw;
        funct3_in = f3; ALU_res_in = addr; rd2_in = rd2; rd_in = rd; flush = fl;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        memop = rd_en | wr_en;
        mis = m_misaligned(f3, addr);
        e_stall = memop && !mis && !fl;
        @(posedge clk); #1;
        e_mis = 1'b0; e_bus = 1'b0;
        zero_memwb();
        if (fl) begin
            e_req = 1'b0;
        end else if (!memop) begin
            e_req = 1'b0;
            e_rw = rw; e_mtr = mtr; e_alu = addr; e_rd = rd;
        end else if (mis) begin
            e_req = 1'b0;
            e_mis = 1'b1;
        end else begin
            e_req = 1'b1; e_we = wr_en; e_addr = addr & ~32'd3;
            e_wdata = m_wdata(f3, rd2); e_be = m_be(f3, addr);
            for (int j = 1; j <= TO; j++) begin
                flush = ($urandom_range(0, 3) == 0);
                if (j == abort_j) begin
                    rst_n = 1'b0;
                    set_nop();
                    e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_bus = 1'b0;
                    zero_memwb();
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    return;
                end
                dmem_ack = (j == ack_k);
                dmem_rdata = (j == ack_k) ? rdata : $urandom;
                e_stall = (j != ack_k);
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                e_mis = 1'b0; e_bus = 1'b0;
                zero_memwb();
                if (j == ack_k) begin
                    e_req = 1'b0;
                    e_rw = rw; e_mtr = mtr; e_alu = addr; e_rd = rd;
                    e_rdata = wr_en ? 32'b0 : m_load(f3, addr, rdata);
                    return;
                end else if (j == TO) begin
                    e_req = 1'b0;
                    e_bus = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_nop();
        dmem_ack = 1'b0; dmem_rdata = '0;
        e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
        e_mis = 1'b0; e_bus = 1'b0;
        zero_memwb();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ALU op passes straight through
        do_op(0, 0, 0, 1, 3'b010, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0, 0);
        check("alu_rw", 32'(regWrite_out), 32'd1);
        check("alu_rd", 32'(rd_out), 32'd5);
        check("alu_res", ALU_res_out, 32'h1234);
        // lb / lbu of the top byte
        do_op(1, 0, 1, 1, 3'b000, 32'h103, 32'h0, 5'd7, 0, 1, 32'h80FF_0000, 0);
        check("lb_data", read_data_out, 32'hFFFF_FF80);
        do_op(1, 0, 1, 1, 3'b100, 32'h103, 32'h0, 5'd7, 0, 1, 32'h80FF_0000, 0);
        check("lbu_data", read_data_out, 32'h0000_0080);
        // sh to upper halfword, slow ack
        do_op(0, 1, 0, 0, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd0, 0, 4, 32'h0, 0);
        check("sh_rw", 32'(regWrite_out), 32'd0);
        // misaligned lw
        do_op(1, 0, 1, 1, 3'b010, 32'h5, 32'h0, 5'd3, 0, 1, 32'h0, 0);
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_rw", 32'(regWrite_out), 32'd0);
        // timeout, then an ALU op
        do_op(1, 0, 1, 1, 3'b010, 32'h40, 32'h0, 5'd9, 0, TO + 1, 32'h0, 0);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_req", 32'(dmem_req), 32'd0);
        do_op(0, 0, 0, 1, 3'b000, 32'hCAFE, 32'h0, 5'd11, 0, 0, 32'h0, 0);
        check("post_to_alu", ALU_res_out, 32'hCAFE);
        // flushed sw
        do_op(0, 1, 0, 0, 3'b010, 32'h300, 32'h1111_2222, 5'd0, 1, 1, 32'h0, 0);
        check("flush_req", 32'(dmem_req), 32'd0);
        check("flush_alu", ALU_res_out, 32'd0);
        // reset mid-BUSY
        do_op(1, 0, 1, 1, 3'b010, 32'h80, 32'h0, 5'd4, 0, TO + 1, 32'h0, 2);
        check("abort_req", 32'(dmem_req), 32'd0);

        for (int i = 0; i < 300; i++) begin
            int kind, ack_k, abort_j;
            logic [2:0] f3;
            bit fl;
            kind = $urandom_range(0, 2);
            f3 = 3'($urandom_range(0, 7));
            if (kind == 2 && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
            fl = ($urandom_range(0, 7) == 0);
            ack_k = $urandom_range(1, TO + 1);
            abort_j = ($urandom_range(0, 39) == 0) ? $urandom_range(1, TO) : 0;
            do_op(kind == 1, kind == 2, 1'($urandom), 1'($urandom), f3, $urandom, $urandom,
                  5'($urandom), fl, ack_k, $urandom, abort_j);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
